ws2812_write_arbiter: RTL

- Shares the single pixel-write port of the ws2812 chain driver (rgb_data / led_num / write) between NUM_REQ independent pixel producers, e.g. a pattern generator and an audio-level meter.
- Picks one pending request round-robin, issues exactly one single-cycle write to the driver, then enforces a minimum idle gap before the next write.
- Sits between the producers and the ws2812 instance, replacing ad-hoc counter-driven write strobes.

---
 rtl/ws2812_pkg.sv | 14 +
 rtl/ws2812_write_arbiter_rr_pick.sv | 31 +++
 rtl/ws2812_write_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants for the ws2812 pixel-write path: data widths, default
// chain length and the arbiter FSM state encoding.
package ws2812_pkg;

  localparam int RGB_W        = 24;
  localparam int LED_IDX_W    = 8;
  localparam int DEF_NUM_LEDS = 60;

  // Arbiter FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

endpackage

// File: rtl/ws2812_write_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set bit of the valid
// vector, searching upward from the pointer and wrapping modulo N.
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_winner,
  output logic             o_any_valid
);

  int   w_idx;
  logic w_found;

  // Scan N candidates starting at the pointer; the first hit wins
  always_comb begin
    w_idx    = 0;
    w_found  = 1'b0;
    o_winner = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!w_found && i_valid[w_idx]) begin
        w_found  = 1'b1;
        o_winner = PTR_W'(w_idx);
      end
    end
    o_any_valid = w_found;
  end

endmodule

// File: rtl/ws2812_write_arbiter.sv
// Shares the ws2812 driver's single pixel-write port between NUM_REQ
// producers. Handshake: a producer holds req_valid/req_rgb/req_led stable
// until it sees its one-cycle req_ready pulse; data is captured at grant
// (IDLE), so later changes do not affect the issued write, and a grant is
// always completed with ready even if valid drops after the grant edge.
// Each issue is followed by WRITE_GAP idle cycles. dbg_state exposes the FSM.
module ws2812_write_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int NUM_REQ   = 2,
  parameter int WRITE_GAP = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*RGB_W-1:0]   req_rgb,
  input  logic [NUM_REQ*LED_IDX_W-1:0] req_led,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [RGB_W-1:0]           rgb_data,
  output logic [LED_IDX_W-1:0]       led_num,
  output logic                       write,
  output logic                       range_err,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [1:0]           r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_win;
  logic [7:0]           r_gap;
  logic [RGB_W-1:0]     r_rgb;
  logic [LED_IDX_W-1:0] r_led;
  logic [NUM_REQ-1:0]   r_ready;
  logic                 r_write;
  logic                 r_range_err;

  logic [PTR_W-1:0]     w_win;
  logic                 w_any;
  logic [RGB_W-1:0]     w_sel_rgb;
  logic [LED_IDX_W-1:0] w_sel_led;
  logic                 w_in_range;
  logic [PTR_W-1:0]     w_ptr_next;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_valid     (req_valid),
    .i_ptr       (r_ptr),
    .o_winner    (w_win),
    .o_any_valid (w_any)
  );

  assign w_sel_rgb  = req_rgb[int'(w_win)*RGB_W +: RGB_W];
  assign w_sel_led  = req_led[int'(w_win)*LED_IDX_W +: LED_IDX_W];
  // Unsigned compare of the 8-bit index against the chain length
  assign w_in_range = (32'(w_sel_led) < 32'(NUM_LEDS));
  // Explicit wrap so non-power-of-two NUM_REQ never points past the last requester
  assign w_ptr_next = (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;

  // FSM: grant in IDLE, one ISSUE cycle with registered strobes, then GAP countdown
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_gap       <= '0;
      r_rgb       <= '0;
      r_led       <= '0;
      r_ready     <= '0;
      r_write     <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rgb       <= w_sel_rgb;
            r_led       <= w_sel_led;
            r_win       <= w_win;
            r_ready     <= NUM_REQ'(1) << w_win;
            r_write     <= w_in_range;
            r_range_err <= !w_in_range;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_ready     <= '0;
          r_write     <= 1'b0;
          r_range_err <= 1'b0;
          r_ptr       <= w_ptr_next;
          r_gap       <= 8'(WRITE_GAP - 1);
          r_state     <= GAP;
        end
        GAP: begin
          if (r_gap == 8'd0) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rgb_data  = r_rgb;
  assign led_num   = r_led;
  assign write     = r_write;
  assign range_err = r_range_err;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule
